// File: rtl/ship_motion_if.sv
// ============================================================================
// ship_motion_if : button/tick inputs and position outputs of the ship mover
// Rev 1.0
// ============================================================================
`default_nettype none

interface ship_motion_if #(
  parameter int WIDTH = 5
);
  logic             left_debounced;
  logic             right_debounced;
  logic             enable;
  logic [WIDTH-1:0] ship_x;
  logic             moved;
  logic             at_left;
  logic             at_right;

  modport master (
    output left_debounced, right_debounced, enable,
    input  ship_x, moved, at_left, at_right
  );

  modport slave (
    input  left_debounced, right_debounced, enable,
    output ship_x, moved, at_left, at_right
  );
endinterface

`default_nettype wire

// File: rtl/ship_motion.sv
// ============================================================================
// ship_motion : ship position with press-step, hold-delay and auto-repeat
// Optional macro SHIP_WRAP_EN: boundary steps wrap to the opposite limit.
// Rev 1.0
// ============================================================================
`default_nettype none

module ship_motion #(
  parameter int WIDTH        = 5,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 19,
  parameter int X_INIT       = 5,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  wire logic       clk_36MHz,
  input  wire logic       reset,
  ship_motion_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);
  localparam logic [WIDTH-1:0]   c_x_min      = WIDTH'(X_MIN);
  localparam logic [WIDTH-1:0]   c_x_max      = WIDTH'(X_MAX);
  localparam logic [WIDTH-1:0]   c_x_init     = WIDTH'(X_INIT);
  localparam logic [WIDTH-1:0]   c_x_one      = WIDTH'(1);

`ifdef SHIP_WRAP_EN
  localparam logic c_wrap = 1'b1;
`else
  localparam logic c_wrap = 1'b0;
`endif

  logic [1:0]         r_state, w_state_next;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
  logic               r_dir, w_dir_next;   // 1 = right, 0 = left
  logic [WIDTH-1:0]   r_ship_x, w_x_next;
  logic               r_moved;
  logic               w_step;
  logic               w_single;
  logic               w_held;

  assign w_single = bus.left_debounced ^ bus.right_debounced;
  assign w_held   = w_single & (bus.right_debounced == r_dir);

  // Everything but the moved pulse freezes between ticks.
  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= c_cnt_zero;
      r_dir    <= 1'b0;
      r_ship_x <= c_x_init;
      r_moved  <= 1'b0;
    end else begin
      r_moved <= bus.enable & w_step & (w_x_next != r_ship_x);
      if (bus.enable) begin
        r_state  <= w_state_next;
        r_cnt    <= w_cnt_next;
        r_dir    <= w_dir_next;
        r_ship_x <= w_x_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_single) begin
          w_step       = 1'b1;
          w_dir_next   = bus.right_debounced;
          w_cnt_next   = c_cnt_zero;
          w_state_next = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!w_held) begin
          w_cnt_next   = c_cnt_zero;
          w_state_next = S_IDLE;
        end else if (r_cnt == c_delay_last) begin
          w_step       = 1'b1;
          w_cnt_next   = c_cnt_zero;
          w_state_next = S_REPEAT;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      S_REPEAT: begin
        if (!w_held) begin
          w_cnt_next   = c_cnt_zero;
          w_state_next = S_IDLE;
        end else if (r_cnt == c_rate_last) begin
          w_step       = 1'b1;
          w_cnt_next   = c_cnt_zero;
        end else begin
          w_cnt_next   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_cnt_next   = c_cnt_zero;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Step target; a step always goes in w_dir_next (it equals r_dir once latched).
  always_comb begin
    w_x_next = r_ship_x;
    if (w_step) begin
      if (w_dir_next) begin
        if (r_ship_x != c_x_max) w_x_next = r_ship_x + c_x_one;
        else if (c_wrap)         w_x_next = c_x_min;
      end else begin
        if (r_ship_x != c_x_min) w_x_next = r_ship_x - c_x_one;
        else if (c_wrap)         w_x_next = c_x_max;
      end
    end
  end

  assign bus.ship_x   = r_ship_x;
  assign bus.moved    = r_moved;
  assign bus.at_left  = (r_ship_x == c_x_min);
  assign bus.at_right = (r_ship_x == c_x_max);

endmodule

`default_nettype wire

// File: tb/tb_ship_motion.sv
// ============================================================================
// tb_ship_motion : randomized and directed checks against a tick-count model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ship_motion;
  localparam int WIDTH = 5;
  localparam int X_MIN = 0;
  localparam int X_MAX = 19;
  localparam int X_INIT = 5;
  localparam int RD = 8;
  localparam int RR = 4;
`ifdef SHIP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk_36MHz = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ship_motion_if #(.WIDTH(WIDTH)) bus();

  ship_motion #(
    .WIDTH(WIDTH), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #14 clk_36MHz = ~clk_36MHz;

  // Model: a run is the number of consecutive ticks one button has been the
  // only one pressed; steps fall on run index 0, RD, RD+RR, RD+2RR, ...
  int m_pos;
  int m_run;
  bit m_dir;
  bit m_moved;

  task automatic model_tick(input bit l, input bit r, input bit en, input bit rst_n);
    bit step;
    int k;
    int np;
    if (!rst_n) begin
      m_pos = X_INIT; m_run = 0; m_dir = 1'b0; m_moved = 1'b0;
      return;
    end
    m_moved = 1'b0;
    if (!en) return;
    step = 1'b0;
    if (m_run == 0) begin
      if (l != r) begin
        m_dir = r; step = 1'b1; m_run = 1;
      end
    end else if ((l != r) && (r == m_dir)) begin
      k = m_run;
      step = (k == RD) || ((k > RD) && (((k - RD) % RR) == 0));
      m_run = m_run + 1;
    end else begin
      m_run = 0;
    end
    if (step) begin
      np = m_pos;
      if (m_dir) np = (m_pos == X_MAX) ? (WRAP ? X_MIN : m_pos) : m_pos + 1;
      else       np = (m_pos == X_MIN) ? (WRAP ? X_MAX : m_pos) : m_pos - 1;
      m_moved = (np != m_pos);
      m_pos = np;
    end
  endtask

  task automatic tick(input bit l, input bit r, input bit en, input bit rst_n);
    bus.left_debounced  = l;
    bus.right_debounced = r;
    bus.enable          = en;
    reset               = rst_n;
    @(posedge clk_36MHz);
    #1;
    model_tick(l, r, en, rst_n);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.ship_x !== 5'd5) begin errors++; $display("FAIL reset_x got %0d expected 5", bus.ship_x); end
    checks++; if (bus.at_left !== 1'b0) begin errors++; $display("FAIL reset_at_left got %b expected 0", bus.at_left); end
    checks++; if (bus.at_right !== 1'b0) begin errors++; $display("FAIL reset_at_right got %b expected 0", bus.at_right); end
    checks++; if (bus.moved !== 1'b0) begin errors++; $display("FAIL reset_moved got %b expected 0", bus.moved); end
  endtask

  task automatic test_single_press();
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.ship_x !== 5'd6) begin errors++; $display("FAIL press_x got %0d expected 6", bus.ship_x); end
    checks++; if (bus.moved !== 1'b1) begin errors++; $display("FAIL press_moved got %b expected 1", bus.moved); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (bus.ship_x !== 5'd6 || bus.moved !== 1'b0) begin
        errors++; $display("FAIL press_idle[%0d] got x=%0d moved=%b expected x=6 moved=0", i, bus.ship_x, bus.moved);
      end
    end
  endtask

  task automatic test_hold_repeat();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      if (bus.moved === 1'b1) pulses++;
      checks++;
      if (bus.ship_x !== m_pos[WIDTH-1:0] || bus.moved !== m_moved) begin
        errors++; $display("FAIL hold[%0d] got x=%0d moved=%b expected x=%0d moved=%b", i, bus.ship_x, bus.moved, m_pos, m_moved);
      end
    end
    checks++; if (bus.ship_x !== 5'd9) begin errors++; $display("FAIL hold_final_x got %0d expected 9", bus.ship_x); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL hold_pulses got %0d expected 4", pulses); end
  endtask

  task automatic test_left_boundary();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 21; i++) tick(1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (bus.ship_x !== 5'd0) begin errors++; $display("FAIL boundary_reach_x got %0d expected 0", bus.ship_x); end
    checks++; if (bus.at_left !== 1'b1) begin errors++; $display("FAIL boundary_at_left got %b expected 1", bus.at_left); end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      if (bus.moved === 1'b1) pulses++;
      checks++;
      if (bus.ship_x !== m_pos[WIDTH-1:0] || bus.moved !== m_moved || bus.at_left !== (m_pos == X_MIN)) begin
        errors++; $display("FAIL boundary[%0d] got x=%0d moved=%b at_left=%b expected x=%0d moved=%b", i, bus.ship_x, bus.moved, bus.at_left, m_pos, m_moved);
      end
`ifdef SHIP_WRAP_EN
      if (i == 0) begin
        checks++;
        if (bus.ship_x !== 5'd19 || bus.moved !== 1'b1 || bus.at_right !== 1'b1) begin
          errors++; $display("FAIL wrap_first got x=%0d moved=%b at_right=%b expected x=19 moved=1 at_right=1", bus.ship_x, bus.moved, bus.at_right);
        end
      end
`endif
    end
`ifndef SHIP_WRAP_EN
    checks++;
    if (pulses != 0 || bus.ship_x !== 5'd0) begin
      errors++; $display("FAIL clamp_final got x=%0d pulses=%0d expected x=0 pulses=0", bus.ship_x, pulses);
    end
`endif
  endtask

  task automatic test_enable_gap();
    int ticks = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b1, (i % 3) == 2, 1'b1);
      if ((i % 3) == 2) ticks++;
      checks++;
      if (bus.ship_x !== m_pos[WIDTH-1:0] || bus.moved !== m_moved) begin
        errors++; $display("FAIL enable_gap[%0d] got x=%0d moved=%b expected x=%0d moved=%b", i, bus.ship_x, bus.moved, m_pos, m_moved);
      end
      if ((i % 3) == 2 && ticks == 9) begin
        checks++;
        if (bus.ship_x !== 5'd7 || bus.moved !== 1'b1) begin
          errors++; $display("FAIL enable_first_repeat got x=%0d moved=%b expected x=7 moved=1", bus.ship_x, bus.moved);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.ship_x !== 5'd8) begin errors++; $display("FAIL b2b_hold_x got %0d expected 8", bus.ship_x); end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.ship_x !== 5'd8 || bus.moved !== 1'b0) begin
      errors++; $display("FAIL b2b_both got x=%0d moved=%b expected x=8 moved=0", bus.ship_x, bus.moved);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.ship_x !== 5'd9 || bus.moved !== 1'b1) begin
      errors++; $display("FAIL b2b_repress got x=%0d moved=%b expected x=9 moved=1", bus.ship_x, bus.moved);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.ship_x !== 5'd5 || bus.moved !== 1'b0 || bus.at_left !== 1'b0 || bus.at_right !== 1'b0) begin
      errors++; $display("FAIL b2b_reset got x=%0d moved=%b expected x=5 moved=0", bus.ship_x, bus.moved);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.ship_x !== 5'd6 || bus.moved !== 1'b1) begin
      errors++; $display("FAIL b2b_after_reset got x=%0d moved=%b expected x=6 moved=1", bus.ship_x, bus.moved);
    end
  endtask

  task automatic test_random();
    bit l = 1'b0;
    bit r = 1'b0;
    bit en;
    bit rst_n;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick(l, r, en, rst_n);
      checks++;
      if (bus.ship_x !== m_pos[WIDTH-1:0] || bus.moved !== m_moved ||
          bus.at_left !== (m_pos == X_MIN) || bus.at_right !== (m_pos == X_MAX)) begin
        errors++;
        $display("FAIL random[%0d] got x=%0d moved=%b al=%b ar=%b expected x=%0d moved=%b", i,
                 bus.ship_x, bus.moved, bus.at_left, bus.at_right, m_pos, m_moved);
      end
    end
  endtask

  initial begin
    bus.left_debounced  = 1'b0;
    bus.right_debounced = 1'b0;
    bus.enable          = 1'b0;
    m_pos = X_INIT; m_run = 0; m_dir = 1'b0; m_moved = 1'b0;
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_left_boundary();
    test_enable_gap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
